async_fifo_lvl: RTL and testbench
=================================

# async_fifo_lvl

Parametrised dual-clock FIFO for crossing streaming valid/ready traffic between unrelated clock domains. It replaces the fixed two-flop, mailbox-style crossing with the following additions:

- a configurable synchroniser depth;
- per-side fill levels with almost-full and almost-empty thresholds;
- optional sticky overflow/underflow error flags.

It sits at every clock boundary between tile-side and uncore-side streaming links.

## Interface

Parameters:

- WIDTH, 32, payload width in bits (≥1)
- DEPTH_LG_2, 2, log2 of entry count; DEPTH = 2**DEPTH_LG_2 (≥1)
- SYNC_STAGES, 2, flops per pointer synchroniser (≥2)
- AF_LEVEL, DEPTH-1, almost_full_w asserts when w_level ≥ AF_LEVEL
- AE_LEVEL, 1, almost_empty_r asserts when r_level ≤ AE_LEVEL

Ports:

- clk_w  in  1  write clock
- reset_w  in  1  write-domain reset; reset reset_w, asynchronous, active-high; clock clk_w
- clk_r  in  1  read clock
- reset_r  in  1  read-domain reset, asynchronous, active-high
- valid_w  in  1  write request
- ready_w  out  1  not full
- data_w  in  WIDTH  write payload
- w_level  out  DEPTH_LG_2+1  occupancy as seen by the write side (conservative)
- almost_full_w  out  1  threshold flag
- valid_r  out  1  not empty
- ready_r  in  1  read accept
- data_r  out  WIDTH  head entry, first-word-fall-through
- r_level  out  DEPTH_LG_2+1  occupancy as seen by the read side (conservative)
- almost_empty_r  out  1  threshold flag
- overflow_w  out  1  sticky; present only with ASYNC_FIFO_ERR_EN
- underflow_r  out  1  sticky; present only with ASYNC_FIFO_ERR_EN

## Operation

- Pointers:
  - Binary and Gray pointers are DEPTH_LG_2+1 bits wide; the MSB is the wrap bit.
  - Only registered Gray pointers cross domains.
  - Memory addresses are the low DEPTH_LG_2 bits of the binary pointers.
- Write side:
  - A write fires when valid_w & ready_w.
  - On fire, data_w is written to mem[wbin], then wbin and wgray increment.
- Read side:
  - A read fires when valid_r & ready_r.
  - On fire, rbin and rgray increment.
  - data_r = mem[rbin] combinationally; it is stable while valid_r=1 and no read fires.
- Levels:
  - w_level = wbin − bin(rgray_sync_w), modulo 2**(DEPTH_LG_2+1).
  - r_level = bin(wgray_sync_r) − rbin, same modulus.
- Flags:
  - ready_w = (w_level != DEPTH).
  - valid_r = (r_level != 0).
- Conservatism: the write side never under-reports occupancy and the read side never over-reports it. Full and empty are therefore safe; their release lags by the synchroniser delay.
- Wrap-around: pointers overflow naturally; the MSB mismatch with equal low bits denotes full.
- Simultaneous write and read:
  - Each side updates only its own pointer.
  - Each side's level changes by +1 or −1 immediately for its own event and by the opposite amount after synchronisation.
- valid_w while full is ignored, with no memory write. ready_r while empty is ignored.
- Reset:
  - Write-domain outputs: wbin=0, ready_w=1, w_level=0, almost_full_w=0, overflow_w=0.
  - Read-domain outputs: rbin=0, valid_r=0, r_level=0, almost_empty_r=1, underflow_r=0.
  - Synchroniser flops reset to 0 in their destination domain.
  - Memory is not reset.
- Reset mid-operation: reset_w and reset_r must be asserted with overlapping windows; the FIFO then empties completely. Single-side reset is unsupported and yields undefined contents.

## Timing

- Write-to-valid_r latency: between SYNC_STAGES and SYNC_STAGES+1 clk_r rising edges after the clk_w edge that fired the write.
- Read-to-ready_w release latency: between SYNC_STAGES and SYNC_STAGES+1 clk_w edges after the freeing read.
- Local level update: w_level and r_level reflect same-domain fires one cycle after the firing edge.
- Throughput: one transfer per clock per side when neither full nor empty.
- Output timing: ready_w, valid_r, the levels and the flags are decoded from registers only; no input-to-output combinational path exists except ready_r and valid_w into the fire terms.

## Configuration

- ASYNC_FIFO_ERR_EN defined:
  - overflow_w sets on valid_w & ~ready_w and stays set until reset_w.
  - underflow_r sets on ready_r & ~valid_r and stays set until reset_r.
- ASYNC_FIFO_ERR_EN undefined: both ports and their logic are absent.

## Structure

- Package async_fifo_pkg holds:
  - bin2gray and gray2bin functions, parametrised by width;
  - the minimum-legal-value constants (DEPTH_LG_2 ≥ 1, SYNC_STAGES ≥ 2).
- One sub-module, async_fifo_ptr_sync: an N-stage, per-bit flop chain for a Gray vector, with async active-high reset, instantiated once per direction.
- Parameter legality is checked by elaboration-time assertions.

## Test plan

Bench configuration for all scenarios: WIDTH=8, DEPTH_LG_2=2, SYNC_STAGES=2, clk_w 10 ns, clk_r 17 ns.

1. Apply reset to both sides -> ready_w=1, valid_r=0, w_level=0, r_level=0, almost_empty_r=1, almost_full_w=0.
2. With ready_r=0, write 0xA0–0xA3 -> after the 4th write, w_level=4, ready_w=0, almost_full_w=1 at level 3; valid_r rises 2–3 clk_r edges after the first write; a 5th valid_w with 0xFF is not stored.
3. Drain the full FIFO with ready_r=1 -> data_r yields 0xA0, 0xA1, 0xA2, 0xA3 in order, then valid_r=0; ready_w returns 2–3 clk_w edges after the first read.
4. Stream 40 sequential bytes with random valid_w/ready_r at 70% duty -> all 40 bytes received in order, with no loss or duplication, across more than 4 pointer wraps.
5. Assert both resets for 3 cycles while holding 2 entries -> all reset values restored, r_level=0, and the next write of 0x55 is the next word read.
6. With ASYNC_FIFO_ERR_EN: write while full -> overflow_w=1 and held until reset_w; read while empty -> underflow_r=1. Without the macro: the ports are absent and scenario 4 still passes.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray conversion and parameter floors.
// Latency: pure functions and constants, no state.
// Backpressure: not applicable.
package async_fifo_pkg;

    // Smallest legal configuration values, checked at elaboration by the FIFO.
    localparam int MIN_DEPTH_LG_2  = 1;
    localparam int MIN_SYNC_STAGES = 2;

    // Widest pointer the conversion helpers handle; callers pass the live width.
    localparam int PTR_MAX_W = 32;

    // Binary to reflected Gray code over the low 'width' bits.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin,
                                                       input int width);
        logic [PTR_MAX_W-1:0] mask;
        logic [PTR_MAX_W-1:0] val;
        mask = (32'd1 << width) - 32'd1;
        val  = bin & mask;
        return val ^ (val >> 1);
    endfunction

    // Reflected Gray code to binary over the low 'width' bits (prefix XOR from the MSB down).
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray,
                                                       input int width);
        logic [PTR_MAX_W-1:0] mask;
        logic [PTR_MAX_W-1:0] g;
        logic [PTR_MAX_W-1:0] bin;
        mask = (32'd1 << width) - 32'd1;
        g    = gray & mask;
        bin  = g;
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = g[i] ^ bin[i+1];
        end
        return bin;
    endfunction

endpackage

// File: rtl/async_fifo_ptr_sync.sv
// Per-bit flop chain carrying a Gray pointer into the destination clock domain.
// Latency: STAGES destination-clock edges.
// Backpressure: none; samples every destination clock.
module async_fifo_ptr_sync #(
    parameter int WIDTH  = 3,
    parameter int STAGES = 2
) (
    input  logic             clkDst,
    input  logic             resetDst,
    input  logic [WIDTH-1:0] grayIn,
    output logic [WIDTH-1:0] graySync
);

    logic [WIDTH-1:0] chain [STAGES];

    // Shift the source Gray value through the chain; clears to zero in the destination domain.
    always_ff @(posedge clkDst or posedge resetDst) begin
        if (resetDst) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= grayIn;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign graySync = chain[STAGES-1];

endmodule

// File: rtl/async_fifo_lvl.sv
// Dual-clock first-word-fall-through FIFO with per-side fill levels and threshold flags.
// Latency: write visible on the read side after SYNC_STAGES..SYNC_STAGES+1 clk_r edges.
// Backpressure: ready_w drops when the write side sees DEPTH entries; valid_r drops when empty.
// Optional macro ASYNC_FIFO_ERR_EN adds sticky overflow_w / underflow_r flags.
module async_fifo_lvl
    import async_fifo_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH_LG_2  = 2,
    parameter int SYNC_STAGES = 2,
    parameter int AF_LEVEL    = (2**DEPTH_LG_2) - 1,
    parameter int AE_LEVEL    = 1
) (
    input  logic                  clk_w,
    input  logic                  reset_w,
    input  logic                  clk_r,
    input  logic                  reset_r,
    input  logic                  valid_w,
    output logic                  ready_w,
    input  logic [WIDTH-1:0]      data_w,
    output logic [DEPTH_LG_2:0]   w_level,
    output logic                  almost_full_w,
    output logic                  valid_r,
    input  logic                  ready_r,
    output logic [WIDTH-1:0]      data_r,
    output logic [DEPTH_LG_2:0]   r_level,
    output logic                  almost_empty_r
`ifdef ASYNC_FIFO_ERR_EN
    ,
    output logic                  overflow_w,
    output logic                  underflow_r
`endif
);

    localparam int DEPTH = 2**DEPTH_LG_2;
    localparam int PW    = DEPTH_LG_2 + 1;

    localparam logic [PW-1:0] DEPTH_CNT = PW'(DEPTH);
    localparam logic [PW-1:0] AF_CNT    = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_CNT    = PW'(AE_LEVEL);

    // Configuration legality, resolved at elaboration.
    if (WIDTH < 1) begin : gErrWidth
        $error("async_fifo_lvl: WIDTH must be at least 1");
    end
    if (DEPTH_LG_2 < MIN_DEPTH_LG_2 || DEPTH_LG_2 > PTR_MAX_W - 2) begin : gErrDepth
        $error("async_fifo_lvl: DEPTH_LG_2 out of range");
    end
    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : gErrSync
        $error("async_fifo_lvl: SYNC_STAGES must be at least 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : gErrAf
        $error("async_fifo_lvl: AF_LEVEL must lie in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : gErrAe
        $error("async_fifo_lvl: AE_LEVEL must lie in 0..DEPTH-1");
    end

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wBin;
    logic [PW-1:0] wGray;
    logic [PW-1:0] wBinNext;
    logic [PW-1:0] wGrayNext;
    logic [PW-1:0] rBin;
    logic [PW-1:0] rGray;
    logic [PW-1:0] rBinNext;
    logic [PW-1:0] rGrayNext;
    logic [PW-1:0] rGraySyncW;
    logic [PW-1:0] wGraySyncR;
    logic [PW-1:0] rBinSyncW;
    logic [PW-1:0] wBinSyncR;
    logic          wFire;
    logic          rFire;

    assign wFire = valid_w & ready_w;
    assign rFire = valid_r & ready_r;

    assign wBinNext  = wBin + PW'(1);
    assign rBinNext  = rBin + PW'(1);
    assign wGrayNext = PW'(bin2gray(PTR_MAX_W'(wBinNext), PW));
    assign rGrayNext = PW'(bin2gray(PTR_MAX_W'(rBinNext), PW));

    // Write pointer pair advances together so the Gray copy is always a registered value.
    always_ff @(posedge clk_w or posedge reset_w) begin
        if (reset_w) begin
            wBin  <= '0;
            wGray <= '0;
        end else if (wFire) begin
            wBin  <= wBinNext;
            wGray <= wGrayNext;
        end
    end

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk_w) begin
        if (wFire) begin
            mem[wBin[DEPTH_LG_2-1:0]] <= data_w;
        end
    end

    // Read pointer pair advances on each accepted head entry.
    always_ff @(posedge clk_r or posedge reset_r) begin
        if (reset_r) begin
            rBin  <= '0;
            rGray <= '0;
        end else if (rFire) begin
            rBin  <= rBinNext;
            rGray <= rGrayNext;
        end
    end

    assign data_r = mem[rBin[DEPTH_LG_2-1:0]];

    async_fifo_ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) uSyncR2W (
        .clkDst   (clk_w),
        .resetDst (reset_w),
        .grayIn   (rGray),
        .graySync (rGraySyncW)
    );

    async_fifo_ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) uSyncW2R (
        .clkDst   (clk_r),
        .resetDst (reset_r),
        .grayIn   (wGray),
        .graySync (wGraySyncR)
    );

    assign rBinSyncW = PW'(gray2bin(PTR_MAX_W'(rGraySyncW), PW));
    assign wBinSyncR = PW'(gray2bin(PTR_MAX_W'(wGraySyncR), PW));

    // The far pointer is stale, so the write side over-counts and the read side under-counts.
    assign w_level       = wBin - rBinSyncW;
    assign ready_w       = (w_level != DEPTH_CNT);
    assign almost_full_w = (w_level >= AF_CNT);

    assign r_level        = wBinSyncR - rBin;
    assign valid_r        = (r_level != '0);
    assign almost_empty_r = (r_level <= AE_CNT);

`ifdef ASYNC_FIFO_ERR_EN
    // Sticky record of a write attempted against a full FIFO.
    always_ff @(posedge clk_w or posedge reset_w) begin
        if (reset_w) begin
            overflow_w <= 1'b0;
        end else if (valid_w & ~ready_w) begin
            overflow_w <= 1'b1;
        end
    end

    // Sticky record of a read attempted against an empty FIFO.
    always_ff @(posedge clk_r or posedge reset_r) begin
        if (reset_r) begin
            underflow_r <= 1'b0;
        end else if (ready_r & ~valid_r) begin
            underflow_r <= 1'b1;
        end
    end
`else
    // Without error tracking, requests against full/empty are simply dropped by the fire terms.
`endif

endmodule

// File: tb/tb_async_fifo_lvl.sv
// Bench for async_fifo_lvl: scenario sequence plus continuous checks against a queue model.
// Latency: clk_w 10 units, clk_r 17 units.
// Backpressure: random valid_w/ready_r duty in the streaming scenario.
module tb_async_fifo_lvl;

    logic       clk_w = 1'b0;
    logic       clk_r = 1'b0;
    logic       reset_w;
    logic       reset_r;
    logic       valid_w;
    logic       ready_w;
    logic [7:0] data_w;
    logic [2:0] w_level;
    logic       almost_full_w;
    logic       valid_r;
    logic       ready_r;
    logic [7:0] data_r;
    logic [2:0] r_level;
    logic       almost_empty_r;
`ifdef ASYNC_FIFO_ERR_EN
    logic       overflow_w;
    logic       underflow_r;
`endif

    always #5 clk_w = ~clk_w;
    initial forever begin
        #8 clk_r = 1'b1;
        #9 clk_r = 1'b0;
    end

    async_fifo_lvl #(
        .WIDTH       (8),
        .DEPTH_LG_2  (2),
        .SYNC_STAGES (2),
        .AF_LEVEL    (3),
        .AE_LEVEL    (1)
    ) dut (
        .clk_w          (clk_w),
        .reset_w        (reset_w),
        .clk_r          (clk_r),
        .reset_r        (reset_r),
        .valid_w        (valid_w),
        .ready_w        (ready_w),
        .data_w         (data_w),
        .w_level        (w_level),
        .almost_full_w  (almost_full_w),
        .valid_r        (valid_r),
        .ready_r        (ready_r),
        .data_r         (data_r),
        .r_level        (r_level),
        .almost_empty_r (almost_empty_r)
`ifdef ASYNC_FIFO_ERR_EN
        ,
        .overflow_w     (overflow_w),
        .underflow_r    (underflow_r)
`endif
    );

    int         tests    = 0;
    int         failures = 0;
    bit         checkEn  = 1'b0;
    logic [7:0] modelQ [$];
    logic [7:0] rxLog  [$];
    int         wrCount  = 0;
    int         rdCount  = 0;
    int         occW;
    int         occR;
    logic [7:0] expD;
    int         n;
    int         sentCnt;
    bit         willFire;

    function automatic void chk(input string name, input bit ok, input int act, input int req);
        tests++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endfunction

    function automatic void chkEq(input string name, input int act, input int req);
        chk(name, act == req, act, req);
    endfunction

    // Model: every accepted write enters the queue in order.
    always @(posedge clk_w) begin
        if (!reset_w && !reset_r && valid_w && ready_w) begin
            modelQ.push_back(data_w);
            wrCount++;
        end
    end

    // Model: every accepted read must present the oldest outstanding word.
    always @(posedge clk_r) begin
        if (!reset_w && !reset_r && valid_r && ready_r) begin
            if (modelQ.size() == 0) begin
                chk("phantom_read", 1'b0, int'(data_r), -1);
            end else begin
                expD = modelQ.pop_front();
                chkEq("read_data", int'(data_r), int'(expD));
            end
            rxLog.push_back(data_r);
            rdCount++;
        end
    end

    // Write side: level never below true occupancy, flags follow the level.
    always @(negedge clk_w) begin
        if (checkEn) begin
            occW = wrCount - rdCount;
            chk("w_level_bound", (int'(w_level) >= occW) && (int'(w_level) <= 4), int'(w_level), occW);
            chkEq("ready_w_vs_level", int'(ready_w), int'(w_level != 3'd4));
            chkEq("almost_full_vs_level", int'(almost_full_w), int'(w_level >= 3'd3));
        end
    end

    // Read side: level never above true occupancy, flags follow the level.
    always @(negedge clk_r) begin
        if (checkEn) begin
            occR = wrCount - rdCount;
            chk("r_level_bound", int'(r_level) <= occR, int'(r_level), occR);
            chkEq("valid_r_vs_level", int'(valid_r), int'(r_level != 3'd0));
            chkEq("almost_empty_vs_level", int'(almost_empty_r), int'(r_level <= 3'd1));
        end
    end

    task automatic resetBoth();
        checkEn = 1'b0;
        @(negedge clk_w);
        reset_w = 1'b1;
        reset_r = 1'b1;
        valid_w = 1'b0;
        ready_r = 1'b0;
        repeat (3) @(posedge clk_r);
        modelQ.delete();
        wrCount = 0;
        rdCount = 0;
        @(negedge clk_w);
        reset_w = 1'b0;
        reset_r = 1'b0;
        repeat (2) @(negedge clk_r);
        checkEn = 1'b1;
    endtask

    task automatic checkResetState();
        @(negedge clk_w);
        chkEq("rst_ready_w", int'(ready_w), 1);
        chkEq("rst_w_level", int'(w_level), 0);
        chkEq("rst_almost_full", int'(almost_full_w), 0);
        @(negedge clk_r);
        chkEq("rst_valid_r", int'(valid_r), 0);
        chkEq("rst_r_level", int'(r_level), 0);
        chkEq("rst_almost_empty", int'(almost_empty_r), 1);
`ifdef ASYNC_FIFO_ERR_EN
        chkEq("rst_overflow", int'(overflow_w), 0);
        chkEq("rst_underflow", int'(underflow_r), 0);
`endif
    endtask

    // Present one word and hold it until accepted; ready_w is stable from negedge to posedge.
    task automatic writeWord(input logic [7:0] d);
        bit done;
        done = 1'b0;
        @(negedge clk_w);
        valid_w = 1'b1;
        data_w  = d;
        for (int i = 0; i < 50; i++) begin
            if (ready_w) begin
                @(posedge clk_w);
                done = 1'b1;
                break;
            end
            @(negedge clk_w);
        end
        #1;
        valid_w = 1'b0;
        chkEq("write_accept", int'(done), 1);
    endtask

    initial begin
        valid_w = 1'b0;
        ready_r = 1'b0;
        data_w  = 8'h00;
        reset_w = 1'b1;
        reset_r = 1'b1;

        // Reset state.
        resetBoth();
        checkResetState();

        // Fill with reads blocked; check valid_r latency after the first write.
        writeWord(8'hA0);
        n = 0;
        do begin
            @(posedge clk_r);
            n++;
            #1;
        end while (!valid_r && n < 8);
        chk("valid_r_latency", (n >= 2) && (n <= 3), n, 2);
        writeWord(8'hA1);
        writeWord(8'hA2);
        @(negedge clk_w);
        chkEq("fill3_w_level", int'(w_level), 3);
        chkEq("fill3_almost_full", int'(almost_full_w), 1);
        chkEq("fill3_ready_w", int'(ready_w), 1);
        writeWord(8'hA3);
        @(negedge clk_w);
        chkEq("full_w_level", int'(w_level), 4);
        chkEq("full_ready_w", int'(ready_w), 0);
        valid_w = 1'b1;
        data_w  = 8'hFF;
        repeat (4) @(negedge clk_w);
        chkEq("full_write_ignored", int'(w_level), 4);
        valid_w = 1'b0;
        repeat (6) @(negedge clk_r);
        chkEq("full_r_level", int'(r_level), 4);
        chkEq("full_valid_r", int'(valid_r), 1);
        chkEq("full_almost_empty", int'(almost_empty_r), 0);
        chkEq("fwft_head", int'(data_r), 8'hA0);

        // Drain; check ready_w release latency after the first read.
        rxLog.delete();
        @(negedge clk_r);
        ready_r = 1'b1;
        @(posedge clk_r);
        #1;
        n = 0;
        do begin
            @(posedge clk_w);
            n++;
            #1;
        end while (!ready_w && n < 8);
        chk("ready_w_latency", (n >= 2) && (n <= 3), n, 2);
        for (int i = 0; i < 40 && rxLog.size() < 4; i++) @(negedge clk_r);
        chkEq("drain_count", rxLog.size(), 4);
        for (int i = 0; i < 4 && i < rxLog.size(); i++) begin
            chkEq("drain_order", int'(rxLog[i]), 8'hA0 + i);
        end
        @(negedge clk_r);
        chkEq("drained_valid_r", int'(valid_r), 0);
        ready_r = 1'b0;
        repeat (6) @(negedge clk_w);
        chkEq("idle_w_level", int'(w_level), 0);
        chkEq("idle_r_level", int'(r_level), 0);

        // Random-duty streaming of 40 sequential bytes.
        rxLog.delete();
        sentCnt = 0;
        fork
            begin
                for (int it = 0; it < 3000 && sentCnt < 40; it++) begin
                    @(negedge clk_w);
                    valid_w  = ($urandom_range(0, 99) < 70);
                    data_w   = 8'(sentCnt);
                    willFire = valid_w && ready_w;
                    @(posedge clk_w);
                    if (willFire) sentCnt++;
                end
                @(negedge clk_w);
                valid_w = 1'b0;
            end
            begin
                for (int it = 0; it < 2000 && rxLog.size() < 40; it++) begin
                    @(negedge clk_r);
                    ready_r = ($urandom_range(0, 99) < 70);
                end
                @(negedge clk_r);
                ready_r = 1'b0;
            end
        join
        chkEq("stream_sent", sentCnt, 40);
        chkEq("stream_received", rxLog.size(), 40);
        for (int i = 0; i < 40 && i < rxLog.size(); i++) begin
            chkEq("stream_order", int'(rxLog[i]), i);
        end

        // Reset with two entries held, then confirm clean restart.
        writeWord(8'h11);
        writeWord(8'h22);
        repeat (6) @(negedge clk_r);
        chkEq("pre_reset_r_level", int'(r_level), 2);
        resetBoth();
        checkResetState();
        writeWord(8'h55);
        for (int i = 0; i < 10 && !valid_r; i++) @(negedge clk_r);
        chkEq("post_reset_valid_r", int'(valid_r), 1);
        chkEq("post_reset_head", int'(data_r), 8'h55);
        rxLog.delete();
        @(negedge clk_r);
        ready_r = 1'b1;
        @(negedge clk_r);
        ready_r = 1'b0;
        chkEq("post_reset_reads", rxLog.size(), 1);
        if (rxLog.size() > 0) chkEq("post_reset_word", int'(rxLog[0]), 8'h55);

`ifdef ASYNC_FIFO_ERR_EN
        // Sticky error flags.
        @(negedge clk_w);
        chkEq("err_ovf_clear", int'(overflow_w), 0);
        chkEq("err_unf_clear", int'(underflow_r), 0);
        writeWord(8'hB0);
        writeWord(8'hB1);
        writeWord(8'hB2);
        writeWord(8'hB3);
        @(negedge clk_w);
        valid_w = 1'b1;
        data_w  = 8'hEE;
        @(negedge clk_w);
        valid_w = 1'b0;
        chkEq("err_ovf_set", int'(overflow_w), 1);
        repeat (5) @(negedge clk_w);
        chkEq("err_ovf_sticky", int'(overflow_w), 1);
        @(negedge clk_r);
        ready_r = 1'b1;
        repeat (12) @(negedge clk_r);
        ready_r = 1'b0;
        chkEq("err_unf_set", int'(underflow_r), 1);
        resetBoth();
        @(negedge clk_r);
        chkEq("err_ovf_reset", int'(overflow_w), 0);
        chkEq("err_unf_reset", int'(underflow_r), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "bench timed out");
    end

endmodule
